// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES key schedule: key-length decode,
// GF(2^8) doubling and word rotation.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_BAD = 2'd3
  } key_len_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } ks_state_t;

  function automatic logic [3:0] nk_of(input key_len_t kl);
    case (kl)
      KL_128:  nk_of = 4'd4;
      KL_192:  nk_of = 4'd6;
      KL_256:  nk_of = 4'd8;
      default: nk_of = 4'd15;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_t kl);
    case (kl)
      KL_128:  nr_of = 4'd10;
      KL_192:  nr_of = 4'd12;
      KL_256:  nr_of = 4'd14;
      default: nr_of = 4'd0;
    endcase
  endfunction

  function automatic logic [5:0] word_total_of(input key_len_t kl);
    case (kl)
      KL_128:  word_total_of = 6'd44;
      KL_192:  word_total_of = 6'd52;
      KL_256:  word_total_of = 6'd60;
      default: word_total_of = 6'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box as a combinational 256-entry lookup.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0x00 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [2047:0] tbl;
  assign tbl = SBOX_TBL;
  assign y   = tbl[11'd2047 - {a, 3'b000} -: 8];

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion: one schedule word per clock into a
// local word store, with a registered 128-bit round-key read port.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8,
  parameter int RD_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      key_len,
  input  logic [255:0]    key_in,
  output logic            busy,
  output logic            done,
  output logic            key_ready,
  output logic            err,
  input  logic [RD_W-1:0] rd_round,
  output logic [127:0]    rd_key
);

  localparam int DEPTH = 4 * (MAX_NK + 7);

  logic [31:0] w_mem [DEPTH];

  ks_state_t   state_q, state_d;
  key_len_t    kl_q, kl_in;
  logic [5:0]  idx_q;
  logic [2:0]  mod_q;
  logic [7:0]  rcon_q;

  logic        accept, err_set, finish, start_legal, last_word;
  logic [5:0]  nk_w;
  logic [3:0]  nk_in;
  logic [31:0] prev_w, back_w, sub_in, sub_out, temp_w, new_w;

  assign kl_in       = key_len_t'(key_len);
  assign nk_in       = nk_of(kl_in);
  assign start_legal = (kl_in != KL_BAD) && (int'(nk_in) <= MAX_NK);
  assign nk_w        = 6'(nk_of(kl_q));
  assign last_word   = (idx_q == word_total_of(kl_q) - 6'd1);
  assign busy        = (state_q == ST_EXPAND);

  // mod_q tracks i mod Nk so no divider is needed for the rcon/SubWord taps.
  assign prev_w = w_mem[idx_q - 6'd1];
  assign back_w = w_mem[idx_q - nk_w];
  assign sub_in = (mod_q == 3'd0) ? rot_word(prev_w) : prev_w;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
  end

  always_comb begin
    temp_w = prev_w;
    if (mod_q == 3'd0)
      temp_w = sub_out ^ {rcon_q, 24'h000000};
    else if (nk_w == 6'd8 && mod_q == 3'd4)
      temp_w = sub_out;
  end

  assign new_w = back_w ^ temp_w;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    err_set = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_legal) begin
            accept  = 1'b1;
            state_d = ST_EXPAND;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_EXPAND: begin
        if (last_word) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      done      <= 1'b0;
      err       <= 1'b0;
      key_ready <= 1'b0;
      kl_q      <= KL_128;
      idx_q     <= 6'd0;
      mod_q     <= 3'd0;
      rcon_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      done    <= finish;
      err     <= err_set;
      if (accept) begin
        key_ready <= 1'b0;
        kl_q      <= kl_in;
        idx_q     <= 6'(nk_in);
        mod_q     <= 3'd0;
        rcon_q    <= 8'h01;
      end else if (state_q == ST_EXPAND) begin
        idx_q <= idx_q + 6'd1;
        mod_q <= (6'(mod_q) == nk_w - 6'd1) ? 3'd0 : mod_q + 3'd1;
        if (mod_q == 3'd0)
          rcon_q <= xtime(rcon_q);
        if (finish)
          key_ready <= 1'b1;
      end
    end
  end

  // Word store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int k = 0; k < MAX_NK; k++)
          if (k < int'(nk_in))
            w_mem[k] <= key_in[255 - 32*k -: 32];
      end else if (state_q == ST_EXPAND) begin
        w_mem[idx_q] <= new_w;
      end
    end
  end

  logic [5:0] rd_base;
  logic       rd_ok;

  assign rd_base = {2'(rd_round), 2'b00} | 6'(rd_round) << 2;
  assign rd_ok   = key_ready && (int'(rd_round) <= int'(nr_of(kl_q))) &&
                   (int'(rd_base) + 3 < DEPTH);

  always_ff @(posedge clk) begin
    if (rst)
      rd_key <= '0;
    else if (rd_ok)
      rd_key <= {w_mem[rd_base], w_mem[rd_base + 6'd1],
                 w_mem[rd_base + 6'd2], w_mem[rd_base + 6'd3]};
    else
      rd_key <= '0;
  end

endmodule
